// File: rtl/wb_resp_fifo_slave_if.sv
// ---------------------------------------------------------------------------
// wb_resp_fifo_slave_if
//   Wishbone classic bus bundle (3-bit address, 8-bit data) between a bus
//   master and the wb_resp_fifo_slave responder.
//   Signals keep the slave-side names so the responder reads like a plain
//   Wishbone slave:
//     wb_addr_i  3  register address        (master -> slave)
//     wb_dat_i   8  write data              (master -> slave)
//     wb_we_i    1  1=write, 0=read         (master -> slave)
//     wb_stb_i   1  strobe/select           (master -> slave)
//     wb_cyc_i   1  valid bus cycle         (master -> slave)
//     wb_dat_o   8  read data, 0 unless ack (slave -> master)
//     wb_ack_o   1  one-cycle acknowledge   (slave -> master)
//     wb_inta_o  1  level interrupt request (slave -> master)
// ---------------------------------------------------------------------------
interface wb_resp_fifo_slave_if;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_dat_i;
    logic       wb_we_i;
    logic       wb_stb_i;
    logic       wb_cyc_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       wb_inta_o;

    modport slave (
        input  wb_addr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_inta_o
    );

    modport master (
        output wb_addr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_inta_o
    );
endinterface

// File: rtl/wb_resp_fifo_slave.sv
// ---------------------------------------------------------------------------
// wb_resp_fifo_slave
//   Known-good Wishbone classic responder used to qualify a WB driver and
//   monitor. Programmable wait states, a small register bank and an 8-bit
//   FIFO behind the DATA register. Raises an interrupt on FIFO threshold or
//   on sticky overflow/underflow errors.
// Ports
//   wb_clk_i  in  bus clock, all logic on the rising edge
//   arst_i    in  asynchronous reset, active-low
//   wb        --  wb_resp_fifo_slave_if.slave bus bundle (addr/data/we/stb/
//                 cyc in, dat/ack/inta out; all outputs registered)
// Register map
//   0 CTRL    rw  [0]EN [1]IEN [2]CLR (write 1 flushes FIFO, reads 0)
//   1 STATUS      [0]EMPTY [1]FULL [2]THR_HIT ro, [3]OVF [4]UNF sticky W1C
//   2 DATA        write pushes, read pops (only while EN=1)
//   3 COUNT   ro  FIFO level, zero-extended
//   4 THRESH  rw  5 SCRATCH rw  6 WAIT rw [2:0]  7 reserved (reads 0)
// ---------------------------------------------------------------------------
module wb_resp_fifo_slave #(
    parameter int         DEPTH    = 8,
    parameter logic [2:0] WAIT_RST = 3'd0
) (
    input  logic                 wb_clk_i,
    input  logic                 arst_i,
    wb_resp_fifo_slave_if.slave  wb
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_DATA    = 3'd2;
    localparam logic [2:0] A_COUNT   = 3'd3;
    localparam logic [2:0] A_THRESH  = 3'd4;
    localparam logic [2:0] A_SCRATCH = 3'd5;
    localparam logic [2:0] A_WAIT    = 3'd6;

    logic [1:0]    state_q,   state_d;
    logic [2:0]    cnt_q,     cnt_d;
    logic [2:0]    addr_q,    addr_d;
    logic          we_q,      we_d;
    logic [7:0]    wdat_q,    wdat_d;
    logic          en_q,      en_d;
    logic          ien_q,     ien_d;
    logic [7:0]    thresh_q,  thresh_d;
    logic [7:0]    scratch_q, scratch_d;
    logic [2:0]    wait_q,    wait_d;
    logic          ovf_q,     ovf_d;
    logic          unf_q,     unf_d;
    logic [LW-1:0] level_q,   level_d;
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic          ack_q,     ack_d;
    logic [7:0]    dat_q,     dat_d;
    logic          inta_q,    inta_d;
    logic [7:0]    mem_q [DEPTH];

    logic          req_s;
    logic          full_s;
    logic          empty_s;
    logic          thr_hit_s;
    logic          push_s;
    logic          ovf_set_s, ovf_clr_s;
    logic          unf_set_s, unf_clr_s;

    // FIFO status flags and threshold comparison from the current level
    always_comb begin
        req_s     = wb.wb_cyc_i & wb.wb_stb_i;
        full_s    = (level_q == LVL_FULL);
        empty_s   = (level_q == {LW{1'b0}});
        thr_hit_s = (thresh_q != 8'h00) && (8'(level_q) >= thresh_q);
    end

    // Bus FSM, register bank and FIFO next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        en_d      = en_q;
        ien_d     = ien_q;
        thresh_d  = thresh_q;
        scratch_d = scratch_q;
        wait_d    = wait_q;
        level_d   = level_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ack_d     = 1'b0;
        dat_d     = 8'h00;
        push_s    = 1'b0;
        ovf_set_s = 1'b0;
        ovf_clr_s = 1'b0;
        unf_set_s = 1'b0;
        unf_clr_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ack_q high means the master is still finishing the previous
                // access; its stb in that cycle is not a new request.
                if (req_s && !ack_q) begin
                    addr_d = wb.wb_addr_i;
                    we_d   = wb.wb_we_i;
                    wdat_d = wb.wb_dat_i;
                    if (wait_q == 3'd0) begin
                        state_d = S_ACK;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_q - 3'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                ack_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Side effects commit on the single edge that leaves ACK
        if (state_q == S_ACK) begin
            if (we_q) begin
                case (addr_q)
                    A_CTRL: begin
                        en_d  = wdat_q[0];
                        ien_d = wdat_q[1];
                        if (wdat_q[2]) begin
                            level_d  = {LW{1'b0}};
                            wr_ptr_d = {PW{1'b0}};
                            rd_ptr_d = {PW{1'b0}};
                        end else begin
                            level_d  = level_q;
                        end
                    end
                    A_STATUS: begin
                        ovf_clr_s = wdat_q[3];
                        unf_clr_s = wdat_q[4];
                    end
                    A_DATA: begin
                        if (!en_q) begin
                            push_s = 1'b0;
                        end else if (full_s) begin
                            ovf_set_s = 1'b1;
                        end else begin
                            push_s   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            level_d  = level_q + LVL_ONE;
                        end
                    end
                    A_THRESH:  thresh_d  = wdat_q;
                    A_SCRATCH: scratch_d = wdat_q;
                    A_WAIT:    wait_d    = wdat_q[2:0];
                    default:   wait_d    = wait_q;
                endcase
            end else begin
                case (addr_q)
                    A_CTRL:   dat_d = {6'b000000, ien_q, en_q};
                    A_STATUS: dat_d = {3'b000, unf_q, ovf_q, thr_hit_s, full_s, empty_s};
                    A_DATA: begin
                        if (!en_q) begin
                            dat_d = 8'h00;
                        end else if (empty_s) begin
                            dat_d     = 8'h00;
                            unf_set_s = 1'b1;
                        end else begin
                            dat_d    = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                            level_d  = level_q - LVL_ONE;
                        end
                    end
                    A_COUNT:   dat_d = 8'(level_q);
                    A_THRESH:  dat_d = thresh_q;
                    A_SCRATCH: dat_d = scratch_q;
                    A_WAIT:    dat_d = {5'b00000, wait_q};
                    default:   dat_d = 8'h00;
                endcase
            end
        end else begin
            dat_d = 8'h00;
        end

        // Sticky error flags: a set event outranks a same-cycle clear
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (unf_set_s) begin
            unf_d = 1'b1;
        end else if (unf_clr_s) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end

        inta_d = ien_q & (thr_hit_s | ovf_q | unf_q);
    end

    // Control/status state and registered bus outputs
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            addr_q    <= 3'd0;
            we_q      <= 1'b0;
            wdat_q    <= 8'h00;
            en_q      <= 1'b0;
            ien_q     <= 1'b0;
            thresh_q  <= 8'h00;
            scratch_q <= 8'h00;
            wait_q    <= WAIT_RST;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            level_q   <= {LW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            ack_q     <= 1'b0;
            dat_q     <= 8'h00;
            inta_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdat_q    <= wdat_d;
            en_q      <= en_d;
            ien_q     <= ien_d;
            thresh_q  <= thresh_d;
            scratch_q <= scratch_d;
            wait_q    <= wait_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            inta_q    <= inta_d;
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wdat_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_inta_o = inta_q;

endmodule

// File: tb/tb_wb_resp_fifo_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_resp_fifo_slave
//   Self-checking bench for wb_resp_fifo_slave. A behavioural register/FIFO
//   model predicts each access; predicted read data and ack latency are queued
//   when the access is driven and popped when the ack arrives.
// ---------------------------------------------------------------------------
module tb_wb_resp_fifo_slave;

    localparam int DEPTH = 8;

    logic clk;
    logic arst_n;
    int   errors;
    int   checks;

    wb_resp_fifo_slave_if wb ();

    wb_resp_fifo_slave #(
        .DEPTH    (DEPTH),
        .WAIT_RST (3'd0)
    ) dut (
        .wb_clk_i (clk),
        .arst_i   (arst_n),
        .wb       (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard queues
    logic [7:0] exp_q [$];
    logic       rd_q  [$];
    int         lat_q [$];

    // reference model state
    logic       m_en, m_ien, m_ovf, m_unf;
    logic [7:0] m_thresh, m_scratch;
    logic [2:0] m_wait;
    logic [7:0] m_fifo [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_ien = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_thresh = 8'h00; m_scratch = 8'h00; m_wait = 3'd0;
        m_fifo.delete();
    endtask

    function automatic logic model_thr();
        return (m_thresh != 8'h00) && (m_fifo.size() >= int'(m_thresh));
    endfunction

    function automatic logic model_inta();
        return m_ien & (model_thr() | m_ovf | m_unf);
    endfunction

    task automatic model_access(input logic [2:0] a, input logic we, input logic [7:0] d,
                                output logic [7:0] ev);
        ev = 8'h00;
        case (a)
            3'd0: if (we) begin
                      if (d[2]) m_fifo.delete();
                      m_en = d[0]; m_ien = d[1];
                  end else ev = {6'b0, m_ien, m_en};
            3'd1: if (we) begin
                      if (d[3]) m_ovf = 1'b0;
                      if (d[4]) m_unf = 1'b0;
                  end else ev = {3'b0, m_unf, m_ovf, model_thr(),
                                 m_fifo.size() == DEPTH, m_fifo.size() == 0};
            3'd2: if (we) begin
                      if (m_en) begin
                          if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
                          else m_fifo.push_back(d);
                      end
                  end else if (m_en) begin
                      if (m_fifo.size() == 0) m_unf = 1'b1;
                      else ev = m_fifo.pop_front();
                  end
            3'd3: if (!we) ev = 8'(m_fifo.size());
            3'd4: if (we) m_thresh = d; else ev = m_thresh;
            3'd5: if (we) m_scratch = d; else ev = m_scratch;
            3'd6: if (we) m_wait = d[2:0]; else ev = {5'b0, m_wait};
            default: ev = 8'h00;
        endcase
    endtask

    // One complete access: predict, drive, wait for ack, compare, release.
    task automatic xfer(input logic [2:0] a, input logic we, input logic [7:0] d);
        logic [7:0] ev;
        logic       got, idle_bad, was_rd;
        int         k, elat;
        lat_q.push_back(int'(m_wait) + 2);
        model_access(a, we, d, ev);
        exp_q.push_back(ev);
        rd_q.push_back(!we);
        @(posedge clk); #1;
        wb.wb_addr_i = a; wb.wb_we_i = we; wb.wb_dat_i = d;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        got = 1'b0; idle_bad = 1'b0; k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            if (wb.wb_ack_o) got = 1'b1;
            else begin
                if (wb.wb_dat_o !== 8'h00) idle_bad = 1'b1;
                k++;
            end
        end
        elat   = lat_q.pop_front();
        ev     = exp_q.pop_front();
        was_rd = rd_q.pop_front();
        check_eq("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check_eq("latency", 32'(k), 32'(elat));
            if (was_rd) check_eq($sformatf("rdata@%0d", a), 32'(wb.wb_dat_o), 32'(ev));
        end
        check_eq("dat_before_ack", 32'(idle_bad), 32'd0);
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        @(negedge clk);
        check_eq("ack_single", 32'(wb.wb_ack_o), 32'd0);
        check_eq("dat_after_ack", 32'(wb.wb_dat_o), 32'd0);
        check_eq("inta", 32'(wb.wb_inta_o), 32'(model_inta()));
    endtask

    // Access abandoned by dropping cyc after drop_after clocks; must not ack.
    task automatic xfer_abort(input logic [2:0] a, input logic we, input logic [7:0] d,
                              input int drop_after);
        logic got;
        @(posedge clk); #1;
        wb.wb_addr_i = a; wb.wb_we_i = we; wb.wb_dat_i = d;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wb.wb_ack_o) got = 1'b1;
            if (k == drop_after) wb.wb_cyc_i = 1'b0;
        end
        wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        check_eq("abort_no_ack", 32'(got), 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        xfer(a, 1'b1, d);
    endtask

    task automatic rd(input logic [2:0] a);
        xfer(a, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        wb.wb_addr_i = 3'd0; wb.wb_dat_i = 8'h00; wb.wb_we_i = 1'b0;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        arst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 32'(wb.wb_ack_o), 32'd0);
        check_eq("rst_dat", 32'(wb.wb_dat_o), 32'd0);
        check_eq("rst_inta", 32'(wb.wb_inta_o), 32'd0);
        arst_n = 1'b1;

        // reset during a wait state: raise inta first via underflow
        wr(3'd0, 8'h03);
        rd(3'd2);
        wr(3'd6, 8'h05);
        @(posedge clk); #1;
        wb.wb_addr_i = 3'd5; wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_eq("midrst_ack", 32'(wb.wb_ack_o), 32'd0);
        check_eq("midrst_dat", 32'(wb.wb_dat_o), 32'd0);
        check_eq("midrst_inta", 32'(wb.wb_inta_o), 32'd0);
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
        rd(3'd3);
        rd(3'd1);
        rd(3'd6);

        // wait states and scratch
        wr(3'd6, 8'h03);
        wr(3'd5, 8'hA5);
        rd(3'd5);
        wr(3'd6, 8'hFF);
        rd(3'd6);
        rd(3'd7);
        wr(3'd7, 8'h5A);
        wr(3'd6, 8'h00);

        // FIFO order and pointer wrap
        wr(3'd0, 8'h01);
        for (int i = 0; i < 8; i++) wr(3'd2, 8'(8'h10 + i));
        rd(3'd3);
        rd(3'd1);
        for (int i = 0; i < 3; i++) rd(3'd2);
        for (int i = 0; i < 3; i++) wr(3'd2, 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) rd(3'd2);
        rd(3'd1);

        // overflow / underflow and write-1-to-clear
        for (int i = 0; i < 9; i++) wr(3'd2, 8'(8'h20 + i));
        rd(3'd1);
        for (int i = 0; i < 8; i++) rd(3'd2);
        rd(3'd2);
        rd(3'd1);
        wr(3'd1, 8'h18);
        rd(3'd1);

        // threshold interrupt
        wr(3'd0, 8'h03);
        wr(3'd4, 8'h04);
        for (int i = 0; i < 4; i++) wr(3'd2, 8'(8'h40 + i));
        rd(3'd1);
        rd(3'd2);

        // aborted access has no side effect
        wr(3'd6, 8'h05);
        rd(3'd3);
        xfer_abort(3'd2, 1'b1, 8'hEE, 2);
        rd(3'd3);
        wr(3'd6, 8'h00);

        // CLR flush, then EN=0 drops pushes and pops
        wr(3'd0, 8'h07);
        rd(3'd3);
        rd(3'd0);
        wr(3'd0, 8'h00);
        wr(3'd2, 8'h99);
        rd(3'd3);
        rd(3'd2);
        rd(3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
